booth_sequencer: RTL and testbench

- Radix-2 Booth signed multiplier controller and datapath.
- Accepts two REG_WIDTH-bit two's-complement operands on a start handshake.
- Runs the add/subtract–arithmetic-shift loop and presents a registered 2*REG_WIDTH product with a one-cycle done strobe.
- Sits directly upstream of the Booth operand/result register bank: product feeds register "in", and done drives its "load".

---
 rtl/booth_sequencer_if.sv | 21 ++
 rtl/booth_sequencer.sv | 118 +++++++++++
 tb/tb_booth_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/booth_sequencer_if.sv
// rtl/booth_sequencer_if.sv - start/operand/product handshake bundle for booth_sequencer
interface booth_sequencer_if #(
    parameter int REG_WIDTH = 8
) ();
    logic                     start;
    logic [REG_WIDTH-1:0]     multiplicand;
    logic [REG_WIDTH-1:0]     multiplier;
    logic                     busy;
    logic                     done;
    logic [2*REG_WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - radix-2 Booth signed multiplier sequencer
// Optional macro BOOTH_SKIP_EN: 00/11 Booth pairs shift inside EVAL instead of visiting SHIFT.
module booth_sequencer #(
    parameter int REG_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    booth_sequencer_if.slave         bus
);
    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(REG_WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SHIFT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [W:0]       a_q, a_d;
    logic [W:0]       mx_q, mx_d;
    logic [W-1:0]     q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   product_q, product_d;

    logic [W:0]       sh_a;
    logic [W-1:0]     sh_q;
    logic [2*W-1:0]   sh_prod;
    logic             last_step;

    // Arithmetic right shift of {A,Q,q_1}; the product is the low 2W bits of the shifted {A,Q}.
    assign sh_a      = {a_q[W], a_q[W:1]};
    assign sh_q      = {a_q[0], q_q[W-1:1]};
    assign sh_prod   = {a_q, q_q[W-1:1]};
    assign last_step = (cnt_q == CW'(1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        mx_d      = mx_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = '0;
                    mx_d    = {bus.multiplicand[W-1], bus.multiplicand};
                    q_d     = bus.multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(W);
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                case ({q_q[0], q1_q})
                    2'b01: begin
                        a_d     = a_q + mx_q;
                        state_d = S_SHIFT;
                    end
                    2'b10: begin
                        a_d     = a_q - mx_q;
                        state_d = S_SHIFT;
                    end
                    default: begin
`ifdef BOOTH_SKIP_EN
                        a_d   = sh_a;
                        q_d   = sh_q;
                        q1_d  = q_q[0];
                        cnt_d = cnt_q - CW'(1);
                        if (last_step) begin
                            product_d = sh_prod;
                            state_d   = S_DONE;
                        end
`else
                        state_d = S_SHIFT;
`endif
                    end
                endcase
            end
            S_SHIFT: begin
                a_d   = sh_a;
                q_d   = sh_q;
                q1_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    product_d = sh_prod;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_EVAL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            mx_q      <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            mx_q      <= mx_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == S_EVAL) || (state_q == S_SHIFT);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_sequencer.sv
// tb/tb_booth_sequencer.sv - scoreboard bench for booth_sequencer (REG_WIDTH=8, either BOOTH_SKIP_EN build)
module tb_booth_sequencer;
    localparam int W = 8;

    logic clk;
    logic rst;

    booth_sequencer_if #(.REG_WIDTH(W)) bus ();

    booth_sequencer #(.REG_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_cmp;
    int             n_err;
    int             done_cnt;
    logic [2*W-1:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [2*W-1:0] a;
        logic signed [2*W-1:0] b;
        a = $signed(m);
        b = $signed(q);
        return a * b;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] q);
        int   p;
        logic prev;
        p    = 0;
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (q[i] != prev) p++;
            prev = q[i];
        end
`ifdef BOOTH_SKIP_EN
        return W + p + 1;
`else
        return 2 * W + 1 + (p - p);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            check("busy_at_done", 64'(bus.busy), 64'(0));
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                check("product", 64'(bus.product), 64'(sb.pop_front()));
            end
        end
    end

    task automatic mul(input logic [W-1:0] m, input logic [W-1:0] q, input bit poke);
        int lat;
        int d0;
        @(negedge clk);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        sb.push_back(model_prod(m, q));
        d0 = done_cnt;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_after_start", 64'(bus.busy), 64'(1));
            if (poke && lat == 5) begin
                bus.start        = 1'b1;
                bus.multiplicand = W'(9);
                bus.multiplier   = W'(9);
            end
            if (poke && lat == 7) bus.start = 1'b0;
        end while (!bus.done && lat < 100);
        check("latency", 64'(lat), 64'(exp_lat(q)));
        @(negedge clk);
        check("done_pulses", 64'(done_cnt - d0), 64'(1));
        check("done_low", 64'(bus.done), 64'(0));
    endtask

    task automatic stream(input int n);
        int             gap;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [W-1:0]   last_q;
        @(negedge clk);
        m = W'($urandom);
        q = W'($urandom);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        sb.push_back(model_prod(m, q));
        last_q = q;
        for (int i = 0; i < n; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!bus.done && gap < 200);
            check("stream_gap", 64'(gap), 64'((i == 0) ? exp_lat(last_q) : exp_lat(last_q) + 1));
            if (i < n - 1) begin
                m = W'($urandom);
                q = W'($urandom);
                bus.multiplicand = m;
                bus.multiplier   = q;
                sb.push_back(model_prod(m, q));
                last_q = q;
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_done_low", 64'(bus.done), 64'(0));
    endtask

    initial begin
        int d0;
        n_cmp            = 0;
        n_err            = 0;
        done_cnt         = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_product", 64'(bus.product), 64'(0));
        rst = 1'b0;

        mul(8'd3,    8'd4,    1'b0);
        mul(8'hFB,   8'd7,    1'b0);
        mul(8'h80,   8'h80,   1'b0);
        mul(8'h80,   8'h7F,   1'b0);
        mul(8'h55,   8'h00,   1'b0);
        mul(8'h55,   8'h01,   1'b0);
        mul(8'hFF,   8'hFF,   1'b0);
        mul(8'h7F,   8'h80,   1'b0);
        mul(8'd12,   8'hF3,   1'b1);

        @(negedge clk);
        bus.multiplicand = 8'h11;
        bus.multiplier   = 8'h22;
        bus.start        = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_product", 64'(bus.product), 64'(0));
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        mul(8'd2, 8'd3, 1'b0);

        stream(1000);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
